// File: rtl/sseg_pkg.sv
// Shared types and constants for the gear-indicator seven-segment scanner.
// Character and anode patterns are active-low.
package sseg_pkg;

  typedef enum logic [1:0] {
    GEAR_NONE = 2'b00,
    GEAR_D    = 2'b01,
    GEAR_N    = 2'b10,
    GEAR_R    = 2'b11
  } gear_t;

  typedef enum logic [1:0] {
    BLINK_IDLE = 2'b00,
    BLINK_OFF  = 2'b01,
    BLINK_ON   = 2'b10
  } blink_t;

  localparam logic [6:0] CHAR_D  = 7'b0100001;
  localparam logic [6:0] CHAR_N  = 7'b0101011;
  localparam logic [6:0] CHAR_R  = 7'b0101111;
  localparam logic [6:0] NO_CHAR = 7'b1111111;

  localparam logic [3:0] AN_0   = 4'b1110;
  localparam logic [3:0] AN_1   = 4'b1101;
  localparam logic [3:0] AN_2   = 4'b1011;
  localparam logic [3:0] AN_3   = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  localparam logic [2:0] BLINK_LAST_HALF = 3'd5;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_0;
      2'd1:    an = AN_1;
      2'd2:    an = AN_2;
      2'd3:    an = AN_3;
      default: an = AN_OFF;
    endcase
    return an;
  endfunction

  // Each gear owns exactly one digit; every other digit stays dark.
  function automatic logic [6:0] char_for(input gear_t g, input logic [1:0] idx);
    logic [6:0] ch;
    case (g)
      GEAR_D:  ch = (idx == 2'd2) ? CHAR_D : NO_CHAR;
      GEAR_N:  ch = (idx == 2'd1) ? CHAR_N : NO_CHAR;
      GEAR_R:  ch = (idx == 2'd0) ? CHAR_R : NO_CHAR;
      default: ch = NO_CHAR;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/sseg_prescaler.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module sseg_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sseg_scan.sv
// Four-digit multiplexed gear indicator (NONE/D/N/R) with registered outputs.
// Optional change-blink of the gear character is enabled by macro SSEG_BLINK_EN.
module sseg_scan
  import sseg_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] gear_in,
  input  logic       gear_vld,
  output logic [3:0] an_sel,
  output logic [6:0] char_sel
);

  localparam int DIV = CLK_HZ / REFRESH_HZ;

  logic       w_tick;
  logic       w_blank;
  logic [1:0] w_idx_next;
  gear_t      r_gear;
  logic [1:0] r_idx;
  logic [3:0] r_an;
  logic [6:0] r_char;

  sseg_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_idx_next = r_idx + 2'd1;

  // Held gear: loaded one cycle after any valid strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gear <= GEAR_NONE;
    end else if (gear_vld) begin
      r_gear <= gear_t'(gear_in);
    end else begin
      r_gear <= r_gear;
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int BT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BLINK_TICKS - 1);

  blink_t          r_blink;
  blink_t          w_blink_next;
  logic [2:0]      r_half;
  logic [2:0]      w_half_next;
  logic [BT_W-1:0] r_bt_cnt;
  logic [BT_W-1:0] w_bt_cnt_next;
  logic            w_start;

  // Only a real change of value (re)starts the blink; restart beats tick accounting.
  assign w_start = gear_vld && (gear_t'(gear_in) != r_gear);
  assign w_blank = (r_blink == BLINK_OFF);

  // Blink state and counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_blink  <= BLINK_IDLE;
      r_half   <= 3'd0;
      r_bt_cnt <= '0;
    end else begin
      r_blink  <= w_blink_next;
      r_half   <= w_half_next;
      r_bt_cnt <= w_bt_cnt_next;
    end
  end

  // Blink next-state: six half-periods of BLINK_TICKS scan ticks, off first.
  always_comb begin
    w_blink_next  = r_blink;
    w_half_next   = r_half;
    w_bt_cnt_next = r_bt_cnt;
    if (w_start) begin
      w_blink_next  = BLINK_OFF;
      w_half_next   = 3'd0;
      w_bt_cnt_next = '0;
    end else if (w_tick && (r_blink != BLINK_IDLE)) begin
      if (r_bt_cnt == BT_LAST) begin
        w_bt_cnt_next = '0;
        if (r_half == BLINK_LAST_HALF) begin
          w_blink_next = BLINK_IDLE;
          w_half_next  = 3'd0;
        end else begin
          w_half_next = r_half + 3'd1;
          case (r_blink)
            BLINK_OFF: w_blink_next = BLINK_ON;
            BLINK_ON:  w_blink_next = BLINK_OFF;
            default:   w_blink_next = BLINK_IDLE;
          endcase
        end
      end else begin
        w_bt_cnt_next = r_bt_cnt + BT_W'(1);
      end
    end else begin
      w_blink_next = r_blink;
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // Digit scan and output registers; both outputs move together on a tick.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx  <= 2'd3;
      r_an   <= AN_OFF;
      r_char <= NO_CHAR;
    end else if (w_tick) begin
      r_idx  <= w_idx_next;
      r_an   <= anode_for(w_idx_next);
      r_char <= w_blank ? NO_CHAR : char_for(r_gear, w_idx_next);
    end else begin
      r_idx  <= r_idx;
      r_an   <= r_an;
      r_char <= r_char;
    end
  end

  assign an_sel   = r_an;
  assign char_sel = r_char;

endmodule

// File: tb/tb_sseg_scan.sv
// Directed, table-driven bench for sseg_scan with DIV=4 and BLINK_TICKS=2.
module tb_sseg_scan;

  localparam logic [6:0] C_D   = 7'b0100001;
  localparam logic [6:0] C_N   = 7'b0101011;
  localparam logic [6:0] C_R   = 7'b0101111;
  localparam logic [6:0] C_OFF = 7'b1111111;

  logic       clk;
  logic       rst;
  logic [1:0] gear_in;
  logic       gear_vld;
  logic [3:0] an_sel;
  logic [6:0] char_sel;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       rst;
    logic [1:0] gear;
    logic       vld;
    int         ncyc;
    logic [3:0] an;
    logic [6:0] ch;
  } vec_t;

  vec_t vecs[$];

  sseg_scan #(
    .CLK_HZ      (8),
    .REFRESH_HZ  (2),
    .BLINK_TICKS (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gear_in  (gear_in),
    .gear_vld (gear_vld),
    .an_sel   (an_sel),
    .char_sel (char_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int id, input logic [3:0] exp_an,
                       input logic [6:0] exp_ch);
    n_total++;
    if (an_sel === exp_an && char_sel === exp_ch) begin
      n_pass++;
    end else begin
      $display("FAIL %s %0d: an_sel=%b char_sel=%b, expected an_sel=%b char_sel=%b",
               name, id, an_sel, char_sel, exp_an, exp_ch);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] g, input logic v, input int n,
                              input logic [3:0] a, input logic [6:0] c);
    vec_t x;
    x.rst = r; x.gear = g; x.vld = v; x.ncyc = n; x.an = a; x.ch = c;
    return x;
  endfunction

`ifdef SSEG_BLINK_EN
  // Walk 16 ticks after loading N at the first cycle; optionally switch to R in tick 5's cycle.
  task automatic blink_run(input bit restart);
    int idx, m, dig;
    bit off;
    logic [6:0] gch, exp_ch;
    rst = 1'b0; gear_in = 2'b00; gear_vld = 1'b0;
    step(); step();
    rst = 1'b1; gear_in = 2'b10; gear_vld = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 3 && restart && n == 5) begin
          gear_in = 2'b11; gear_vld = 1'b1;
        end
        step();
        gear_vld = 1'b0;
      end
      idx = (n - 1) % 4;
      if (restart && n > 5) begin
        m = n - 5; dig = 0; gch = C_R;
      end else begin
        m = n; dig = 1; gch = C_N;
      end
      off = (m <= 12) && (((m - 1) / 2) % 2 == 0);
      exp_ch = (idx == dig && !off) ? gch : C_OFF;
      check(restart ? "blink_restart" : "blink", n, 4'b1111 ^ (4'b0001 << idx), exp_ch);
    end
  endtask
`endif

  initial begin
    rst = 1'b0; gear_in = 2'b00; gear_vld = 1'b0;

`ifndef SSEG_BLINK_EN
    // Reset state and first-tick timing
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 3, 4'b1111, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 3, 4'b1111, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1, 4'b1110, C_OFF));   // t=4
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1101, C_OFF));   // t=8
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1011, C_OFF));   // t=12
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b0111, C_OFF));   // t=16
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1110, C_OFF));   // t=20
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 2, 4'b1110, C_OFF));   // t=22 between ticks
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 2, 4'b1101, C_OFF));   // t=24
    // Gear D pulsed once, then gear_in changed without vld
    vecs.push_back(mk(1'b1, 2'b01, 1'b1, 4, 4'b1011, C_D));     // t=28
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b0111, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1110, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1101, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1011, C_D));     // t=44
    // R then N
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 4, 4'b0111, C_OFF));   // t=48
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1110, C_R));     // t=52
    vecs.push_back(mk(1'b1, 2'b10, 1'b1, 4, 4'b1101, C_N));     // t=56
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1011, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b0111, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1110, C_OFF));   // t=68 no stale R
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1101, C_N));     // t=72
    // vld coincident with the tick that lands on digit 0
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 3, 4'b1101, C_N));     // t=75
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1, 4'b1011, C_OFF));   // t=76
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b0111, C_OFF));   // t=80
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 3, 4'b0111, C_OFF));   // t=83
    vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1, 4'b1110, C_OFF));   // t=84 old gear N
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1101, C_OFF));   // t=88 new gear R
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1011, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b0111, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1110, C_R));     // t=100
    // One-cycle reset mid-scan with gear R
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 2, 4'b1110, C_R));     // t=102
    vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1, 4'b1111, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 3, 4'b1111, C_OFF));
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1, 4'b1110, C_OFF));   // gear NONE after reset
    vecs.push_back(mk(1'b1, 2'b00, 1'b0, 4, 4'b1101, C_OFF));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; gear_in = vecs[i].gear; gear_vld = vecs[i].vld;
      step();
      gear_vld = 1'b0;
      for (int k = 1; k < vecs[i].ncyc; k++) step();
      check("vec", i, vecs[i].an, vecs[i].ch);
    end
`else
    blink_run(1'b0);
    blink_run(1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
